frame_tx: RTL and testbench
===========================

# frame_tx

Memory-to-stream frame transmitter on the core's bus. The ex stage starts it with a word base address and length. It fetches the words over its own bus master port and emits a framed byte stream: header, ID, length, payload, checksum. It then reports completion and a running frame ID back to the core. A small word FIFO decouples bus fetches from the byte stream, so stalls on either side do not corrupt the frame.

## Interface
Parameters:
- `HDR_BYTE`, 8'hA5, first byte of every frame.
- `FIFO_DEPTH`, 4, word FIFO entries (power of 2, ≥2).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle start request from ex; sampled only in IDLE.
- `base_addr_i`  in  32  first word address (bits [1:0] ignored, forced 0).
- `len_i`  in  16  payload length in words; 0 is legal.
- `busy_o`  out  1  frame in progress.
- `done_o`  out  1  one-cycle pulse at frame completion.
- `id_o`  out  32  count of completed frames.
- `mem_req_o`  out  1  bus read request.
- `mem_we_o`  out  1  constant 0.
- `mem_addr_o`  out  32  read address.
- `mem_rdata_i`  in  32  read data, valid in the cycle `mem_req_o && mem_gnt_i`.
- `mem_gnt_i`  in  1  bus grant; low means the bus is holding this master.
- `tx_data_o`  out  8  stream byte.
- `tx_valid_o`  out  1  byte valid.
- `tx_ready_i`  in  1  sink ready; a byte transfers when `tx_valid_o && tx_ready_i`.

## Operation
- Frame byte order: `HDR_BYTE`, ID[7:0], LEN[7:0], LEN[15:8], payload bytes, CSUM.
  - Payload is each word LSB-first, words in ascending address order.
  - CSUM is the 8-bit modular sum of payload bytes only.
- ID[7:0] is `id_o[7:0]` at start acceptance.
- Emit FSM:
  - IDLE: on `start_i`, latch base and len, clear CSUM, go to HDR.
  - HDR: 4 header bytes, then PAYLOAD, or CSUM directly if len = 0.
  - PAYLOAD: pops one FIFO word per 4 bytes sent; after the last byte of the last word, go to CSUM.
  - CSUM: one byte, then IDLE.
- Fetch engine:
  - Runs from start acceptance until len words have been read.
  - `mem_req_o` = fetch remaining && FIFO not full. Occupancy counted before any same-cycle pop.
  - On grant: push `mem_rdata_i`, advance the address by 4 (wraps modulo 2^32), decrement the remaining count.
  - Address and request stay stable while `mem_gnt_i` is low.
- FIFO empty in PAYLOAD: `tx_valid_o` = 0 until a word arrives; no byte is skipped or repeated.
- Simultaneous push and pop on a full FIFO is not possible, because the request is gated by full. Simultaneous push and pop otherwise keeps occupancy unchanged.
- `start_i` while busy is ignored; no queuing.
- `id_o` increments by 1 on `done_o` and wraps at 2^32.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `id_o`=0, `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `tx_valid_o`=0, `tx_data_o`=0. FIFO is emptied and FSM is in IDLE.
- Reset asserted mid-frame aborts immediately. No done pulse; ID is not incremented.
- Start handling:
  - Start accepted at edge N.
  - From cycle N+1: `busy_o`=1, `tx_valid_o`=1 with `HDR_BYTE`, `mem_req_o`=1 (if len > 0), `mem_addr_o`=base.
- Once `tx_valid_o` is high, `tx_data_o` is held stable until the byte transfers.
- Minimum fetch latency: a word granted at edge M can be sent from cycle M+1. Sustained throughput is 1 byte/cycle when grant and ready are continuously high.
- Completion:
  - CSUM transfers at edge K.
  - In cycle K+1: `done_o`=1, `busy_o`=0, `id_o` shows the new count, FSM in IDLE.
  - A `start_i` in cycle K+1 is accepted.

## Structure
- Shared defines file: frame byte-position constants, FSM state encodings, and the `HDR_BYTE` default. Use the existing `MemAddrBus`/`MemBus` widths.
- One sub-module, `frame_tx_fifo`: synchronous word FIFO with push/pop and full/empty, parameterised by `FIFO_DEPTH`, async active-low reset.
- Top level holds the emit FSM, fetch engine, checksum and ID counter.

## Test plan
- Basic frame:
  - Stimulus: base=0x1000_0000, len=2, memory words 0x04030201 and 0x08070605, grant and ready tied high.
  - Required stream: A5 00 02 00 01 02 03 04 05 06 07 08 24.
  - Then `done_o` pulses for 1 cycle and `id_o`=1.
- len=0: stream A5 <id> 00 00 00; no `mem_req_o` ever; done pulses.
- Backpressure:
  - Stimulus: len=8, `tx_ready_i` low for 5 cycles mid-payload.
  - Required: `tx_data_o` stable throughout, FIFO fills to 4 and `mem_req_o` drops, no bytes lost.
- Bus hold:
  - Stimulus: `mem_gnt_i` low for 10 cycles at the 2nd fetch.
  - Required: `mem_addr_o` held at base+4, `tx_valid_o` low once the FIFO empties, frame contents intact.
- Start while busy is ignored. A back-to-back start in the done cycle produces a second frame with ID byte 01 and `id_o`=2 at its end.
- Reset asserted mid-payload: all outputs at reset values on the next cycle, `id_o`=0. A new start runs a correct frame.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// ============================================================================
// Module   : frame_tx_pkg
// Brief    : Shared widths, frame byte positions and emit FSM encodings for
//            the frame transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package frame_tx_pkg;

    // Core bus widths (MemAddrBus / MemBus)
    localparam int c_mem_addr_bus_w = 32;
    localparam int c_mem_bus_w      = 32;
    localparam int c_len_w          = 16;

    localparam logic [7:0] c_hdr_byte_default = 8'hA5;

    // Header byte positions within the frame
    localparam logic [1:0] c_pos_hdr    = 2'd0;
    localparam logic [1:0] c_pos_id     = 2'd1;
    localparam logic [1:0] c_pos_len_lo = 2'd2;
    localparam logic [1:0] c_pos_len_hi = 2'd3;

    localparam int c_st_w = 2;
    localparam logic [c_st_w-1:0] c_st_idle    = 2'd0;
    localparam logic [c_st_w-1:0] c_st_hdr     = 2'd1;
    localparam logic [c_st_w-1:0] c_st_payload = 2'd2;
    localparam logic [c_st_w-1:0] c_st_csum    = 2'd3;

    function automatic logic [7:0] word_byte(input logic [c_mem_bus_w-1:0] w,
                                             input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_tx_fifo.sv
// ============================================================================
// Module   : frame_tx_fifo
// Brief    : Synchronous word FIFO with registered occupancy and full/empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tx_fifo #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_depth_cnt = (c_aw + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_depth_cnt);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage needs no reset: occupancy alone decides what is readable
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_tx.sv
// ============================================================================
// Module   : frame_tx
// Brief    : Memory-to-stream frame transmitter: fetches words over a bus
//            master port and emits header, ID, length, payload, checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_tx
    import frame_tx_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE   = c_hdr_byte_default,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    input  logic [c_mem_addr_bus_w-1:0] base_addr_i,
    input  logic [c_len_w-1:0]          len_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [31:0]                 id_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [c_mem_addr_bus_w-1:0] mem_addr_o,
    input  logic [c_mem_bus_w-1:0]      mem_rdata_i,
    input  logic                        mem_gnt_i,
    output logic [7:0]                  tx_data_o,
    output logic                        tx_valid_o,
    input  logic                        tx_ready_i
);

    logic [c_st_w-1:0]           r_state;
    logic [1:0]                  r_byte_idx;
    logic [c_len_w-1:0]          r_len;
    logic [c_len_w-1:0]          r_words_left;
    logic [c_len_w-1:0]          r_fetch_left;
    logic [7:0]                  r_csum;
    logic [31:0]                 r_id;
    logic                        r_done;
    logic [c_mem_addr_bus_w-1:0] r_addr;

    logic [c_mem_bus_w-1:0]      w_fifo_rdata;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic                        w_grant;
    logic                        w_start;
    logic                        w_xfer;
    logic                        w_pop;
    logic                        w_tx_valid;
    logic [7:0]                  w_tx_data;
    logic [c_mem_addr_bus_w-1:0] w_base_aligned;

    assign w_start        = start_i && (r_state == c_st_idle);
    assign w_base_aligned = base_addr_i & ~32'h3;
    // Full is the registered occupancy, so a same-cycle pop never re-opens it
    assign mem_req_o      = (r_fetch_left != '0) && !w_fifo_full;
    assign w_grant        = mem_req_o && mem_gnt_i;
    assign mem_we_o       = 1'b0;
    assign mem_addr_o     = r_addr;

    frame_tx_fifo #(
        .WIDTH      (c_mem_bus_w),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_wdata (mem_rdata_i),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_fetch_left <= '0;
        end else if (w_start) begin
            r_addr       <= w_base_aligned;
            r_fetch_left <= len_i;
        end else if (w_grant) begin
            r_addr       <= r_addr + 32'd4;
            r_fetch_left <= r_fetch_left - 16'd1;
        end
    end

    // Outputs decode only registered state, so data holds until it transfers
    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        case (r_state)
            c_st_hdr: begin
                w_tx_valid = 1'b1;
                case (r_byte_idx)
                    c_pos_hdr:    w_tx_data = HDR_BYTE;
                    c_pos_id:     w_tx_data = r_id[7:0];
                    c_pos_len_lo: w_tx_data = r_len[7:0];
                    c_pos_len_hi: w_tx_data = r_len[15:8];
                    default:      w_tx_data = 8'h00;
                endcase
            end
            c_st_payload: begin
                w_tx_valid = !w_fifo_empty;
                w_tx_data  = word_byte(w_fifo_rdata, r_byte_idx);
            end
            c_st_csum: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_csum;
            end
            default: begin
                w_tx_valid = 1'b0;
                w_tx_data  = 8'h00;
            end
        endcase
    end

    assign w_xfer = w_tx_valid && tx_ready_i;
    assign w_pop  = w_xfer && (r_state == c_st_payload) && (r_byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_byte_idx   <= '0;
            r_len        <= '0;
            r_words_left <= '0;
            r_csum       <= '0;
            r_id         <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_len        <= len_i;
                        r_words_left <= len_i;
                        r_csum       <= '0;
                        r_byte_idx   <= '0;
                        r_state      <= c_st_hdr;
                    end
                end
                c_st_hdr: begin
                    if (w_xfer) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == c_pos_len_hi) begin
                            r_state <= (r_len == '0) ? c_st_csum : c_st_payload;
                        end
                    end
                end
                c_st_payload: begin
                    if (w_xfer) begin
                        r_csum     <= r_csum + w_tx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_words_left <= r_words_left - 16'd1;
                            if (r_words_left == 16'd1) begin
                                r_state <= c_st_csum;
                            end
                        end
                    end
                end
                c_st_csum: begin
                    if (w_xfer) begin
                        r_state <= c_st_idle;
                        r_done  <= 1'b1;
                        r_id    <= r_id + 32'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign busy_o     = (r_state != c_st_idle);
    assign done_o     = r_done;
    assign id_o       = r_id;
    assign tx_valid_o = w_tx_valid;
    assign tx_data_o  = w_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_frame_tx.sv
// ============================================================================
// Module   : tb_frame_tx
// Brief    : Self-checking bench for frame_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_tx;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o, mem_req_o, mem_we_o, tx_valid_o;
    logic [31:0] id_o, mem_addr_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_gnt_i = 1'b1;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b1;

    always #5 clk = ~clk;

    frame_tx #(.HDR_BYTE(8'hA5), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .id_o(id_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_gnt_i(mem_gnt_i), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Memory: a fixed table for the literal test, otherwise a keyed hash of the address
    bit          use_tbl = 1'b0;
    logic [31:0] tbl [8];
    logic [31:0] key = 32'h1234_5678;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (use_tbl) return tbl[a[4:2]];
        return (a ^ key) * 32'h0100_0193 + 32'h9E37_79B9;
    endfunction

    always @(negedge clk) mem_rdata_i = mem_word(mem_addr_o);

    // Frame-level model: expected byte queue plus occupancy / fetch bookkeeping
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [31:0] m_id = '0;
    logic [31:0] m_fetch_addr = '0;
    int          m_fetch_left = 0;
    int          m_occ = 0;
    int          m_pos = 0;
    int          m_len = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    always @(negedge clk) begin
        bit exp_req, exp_valid, grant, xfer, was_busy, nxt_done;
        logic [31:0] wd, base;
        logic [7:0]  cs;
        if (!rst) begin
            chk("rst_busy",  32'(busy_o), 0);
            chk("rst_done",  32'(done_o), 0);
            chk("rst_id",    id_o, 0);
            chk("rst_req",   32'(mem_req_o), 0);
            chk("rst_we",    32'(mem_we_o), 0);
            chk("rst_addr",  mem_addr_o, 0);
            chk("rst_valid", 32'(tx_valid_o), 0);
            chk("rst_data",  32'(tx_data_o), 0);
            m_busy = 0; m_done = 0; m_id = '0; m_occ = 0; m_pos = 0;
            m_len = 0; m_fetch_left = 0; exp_q.delete();
        end else begin
            exp_req   = m_busy && (m_fetch_left > 0) && (m_occ < FIFO_DEPTH);
            exp_valid = m_busy && (m_pos < 4 || m_pos == 4 + 4 * m_len || m_occ > 0);
            chk("busy",  32'(busy_o), 32'(m_busy));
            chk("done",  32'(done_o), 32'(m_done));
            chk("id",    id_o, m_id);
            chk("we",    32'(mem_we_o), 0);
            chk("req",   32'(mem_req_o), 32'(exp_req));
            chk("valid", 32'(tx_valid_o), 32'(exp_valid));
            if (exp_req) chk("addr", mem_addr_o, m_fetch_addr);
            if (exp_valid && exp_q.size() > 0) chk("data", 32'(tx_data_o), 32'(exp_q[0]));
            grant    = exp_req && mem_gnt_i;
            xfer     = exp_valid && tx_ready_i && (exp_q.size() > 0);
            was_busy = m_busy;
            nxt_done = 0;
            if (xfer) begin
                got_q.push_back(tx_data_o);
                if (m_pos >= 4 && m_pos < 4 + 4 * m_len && ((m_pos - 4) % 4) == 3) m_occ--;
                if (m_pos == 4 + 4 * m_len) begin
                    nxt_done = 1; m_busy = 0; m_id = m_id + 1;
                end
                m_pos++;
                void'(exp_q.pop_front());
            end
            if (grant) begin
                m_occ++; m_fetch_left--; m_fetch_addr = m_fetch_addr + 32'd4;
            end
            if (!was_busy && start_i) begin
                base = base_addr_i & ~32'h3;
                m_len = int'(len_i);
                exp_q.delete();
                exp_q.push_back(8'hA5);
                exp_q.push_back(m_id[7:0]);
                exp_q.push_back(len_i[7:0]);
                exp_q.push_back(len_i[15:8]);
                cs = 8'h00;
                for (int w = 0; w < m_len; w++) begin
                    wd = mem_word(base + 32'(4 * w));
                    for (int b = 0; b < 4; b++) begin
                        exp_q.push_back(wd[8*b +: 8]);
                        cs = cs + wd[8*b +: 8];
                    end
                end
                exp_q.push_back(cs);
                m_pos = 0; m_occ = 0; m_fetch_left = m_len;
                m_fetch_addr = base; m_busy = 1;
            end
            m_done = nxt_done;
        end
    end

    bit rand_mode = 1'b0;
    int rdy_pct = 100;
    int gnt_pct = 100;

    task automatic pulse_now(input logic [31:0] b, input logic [15:0] l);
        base_addr_i = b; len_i = l; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic start_frame(input logic [31:0] b, input logic [15:0] l);
        @(posedge clk); #1;
        pulse_now(b, l);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_o) begin seen = 1'b1; break; end
            if (rand_mode) begin
                tx_ready_i = ($urandom_range(0, 99) < rdy_pct);
                mem_gnt_i  = ($urandom_range(0, 99) < gnt_pct);
                start_i    = m_busy && ($urandom_range(0, 15) == 0);
                if (start_i) begin base_addr_i = $urandom; len_i = 16'($urandom); end
            end
        end
        start_i = 1'b0;
        chk("done_timeout", 32'(seen), 1);
    endtask

    task automatic wait_bytes(input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (got_q.size() >= n) begin seen = 1'b1; break; end
        end
        chk("bytes_timeout", 32'(seen), 1);
    endtask

    logic [7:0] lit1 [13] = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03,
                              8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h24};

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Basic frame against literal bytes
        use_tbl = 1'b1; tbl[0] = 32'h0403_0201; tbl[1] = 32'h0807_0605;
        got_q.delete();
        start_frame(32'h1000_0000, 16'd2);
        wait_done(200);
        chk("basic_len", 32'(got_q.size()), 13);
        for (int i = 0; i < 13 && i < got_q.size(); i++) chk("basic_byte", 32'(got_q[i]), 32'(lit1[i]));
        chk("basic_id", id_o, 1);
        chk("basic_done", 32'(done_o), 1);
        use_tbl = 1'b0;

        // Zero-length frame
        got_q.delete();
        start_frame(32'h0000_0abc, 16'd0);
        wait_done(50);
        chk("len0_size", 32'(got_q.size()), 5);
        if (got_q.size() == 5) begin
            chk("len0_hdr", 32'(got_q[0]), 32'hA5);
            chk("len0_id",  32'(got_q[1]), 32'h01);
            chk("len0_l0",  32'(got_q[2]), 0);
            chk("len0_l1",  32'(got_q[3]), 0);
            chk("len0_cs",  32'(got_q[4]), 0);
        end

        // Sink backpressure mid-payload
        got_q.delete();
        start_frame(32'h2000_0000, 16'd8);
        wait_bytes(6);
        tx_ready_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("bp_req_low", 32'(mem_req_o), 0);
        chk("bp_valid",   32'(tx_valid_o), 1);
        tx_ready_i = 1'b1;
        wait_done(200);
        chk("bp_size", 32'(got_q.size()), 37);

        // Bus hold at the second fetch
        got_q.delete();
        start_frame(32'h3000_0100, 16'd4);
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("hold_addr",  mem_addr_o, 32'h3000_0104);
        chk("hold_req",   32'(mem_req_o), 1);
        chk("hold_valid", 32'(tx_valid_o), 0);
        @(posedge clk); #1;
        mem_gnt_i = 1'b1;
        wait_done(200);
        chk("hold_size", 32'(got_q.size()), 21);

        // Start while busy ignored, then back-to-back start in the done cycle
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        got_q.delete();
        start_frame(32'h4000_0000, 16'd2);
        repeat (3) begin @(posedge clk); #1; end
        pulse_now(32'h4800_0000, 16'd5);
        wait_done(200);
        chk("b2b_first_size", 32'(got_q.size()), 13);
        got_q.delete();
        pulse_now(32'h5000_0000, 16'd1);
        wait_done(200);
        chk("b2b_size", 32'(got_q.size()), 9);
        if (got_q.size() > 1) chk("b2b_idbyte", 32'(got_q[1]), 32'h01);
        chk("b2b_id", id_o, 2);

        // Reset mid-payload, then a clean frame
        got_q.delete();
        start_frame(32'h6000_0000, 16'd8);
        wait_bytes(8);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_busy",  32'(busy_o), 0);
        chk("mrst_id",    id_o, 0);
        chk("mrst_req",   32'(mem_req_o), 0);
        chk("mrst_valid", 32'(tx_valid_o), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        got_q.delete();
        start_frame(32'h7000_0000, 16'd3);
        wait_done(200);
        chk("mrst_size", 32'(got_q.size()), 17);
        if (got_q.size() > 1) chk("mrst_idbyte", 32'(got_q[1]), 0);
        chk("mrst_newid", id_o, 1);

        // Randomized frames, stalls on both sides, spurious starts while busy
        rand_mode = 1'b1;
        for (int f = 0; f < 25; f++) begin
            key     = $urandom;
            rdy_pct = $urandom_range(30, 100);
            gnt_pct = $urandom_range(30, 100);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            start_frame((f % 5 == 0) ? 32'hFFFF_FFF0 : $urandom, 16'($urandom_range(0, 24)));
            wait_done(3000);
        end
        rand_mode = 1'b0;
        tx_ready_i = 1'b1; mem_gnt_i = 1'b1;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
